uart_tx_cfg: RTL
================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter UART_BPS, default 9600: line bit rate, bits/s.
REQ-002 SHALL have parameter CLK_FREQ, default 50_000_000: clk frequency, Hz.
REQ-003 SHALL have parameter DATA_BITS, default 8: payload bits per frame, legal 5..8.
REQ-004 SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter STOP_BITS, default 1: stop bits per frame, legal 1..2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4: entries in the optional FIFO, a power of two, minimum 2.
REQ-007 SHALL have port clk, input, 1: single clock; all logic rises on posedge clk.
REQ-008 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port tx_data, input, 8: payload; only bits [DATA_BITS-1:0] are used.
REQ-010 SHALL have port tx_valid, input, 1: tx_data is valid this cycle.
REQ-011 SHALL have port tx_ready, output, 1: the block accepts tx_data this cycle.
REQ-012 SHALL have port tx_busy, output, 1: a frame is in progress (state != IDLE).
REQ-013 SHALL have port tx_done, output, 1: one-cycle pulse on the last cycle of the final stop bit.
REQ-014 SHALL have port rs232_tx, output, 1: serial line, registered, idle high.

Function
REQ-015 SHALL define BAUD_DIV = CLK_FREQ/UART_BPS, integer division; every line bit lasts exactly BAUD_DIV clk cycles; BAUD_DIV < 2 is an elaboration error.
REQ-016 SHALL size the baud counter at $clog2(BAUD_DIV) bits, count 0..BAUD_DIV-1, wrap to 0, and hold at 0 in IDLE.
REQ-017 SHALL use FSM states IDLE, START, DATA, PAR, STOP; transitions occur only at baud-counter wrap, except IDLE->START.
REQ-018 SHALL transfer data when tx_valid && tx_ready on a rising edge; the payload is captured in a shift register on that edge.
REQ-019 SHALL, without FIFO, drive tx_ready = (state == IDLE) && !rst; IDLE->START happens on the accepting edge, and rs232_tx goes low on the following cycle.
REQ-020 SHALL shift DATA LSB-first and count DATA_BITS bits; DATA->PAR if PARITY != 0, else DATA->STOP.
REQ-021 SHALL make the PAR bit the XOR of the payload bits for even parity and its inverse for odd parity.
REQ-022 SHALL drive STOP high for STOP_BITS bit periods, then go to IDLE and pulse tx_done on the last STOP cycle.
REQ-023 SHALL ignore tx_data changes after capture; tx_valid while not ready is not accepted and is not lost by the source.
REQ-024 SHALL keep frames back-to-back when a new byte is accepted in the IDLE cycle after tx_done, with no gap beyond that one IDLE cycle.

Reset
REQ-025 SHALL, on rst, set rs232_tx=1, tx_busy=0, tx_done=0, tx_ready=0, state=IDLE, counters=0 on the next edge.
REQ-026 SHALL, on rst mid-frame, abort the frame and drive the line high the cycle after; with FIFO, it clears the pointers and discards contents.

Configuration
REQ-027 SHALL use macro UART_TX_FIFO_EN: when defined, a FIFO_DEPTH-entry FIFO sits between the handshake and the FSM, with tx_ready = !full.
REQ-028 SHALL, with UART_TX_FIFO_EN, make the FSM pop when IDLE && !empty, so line start is 2 cycles after acceptance into an empty FIFO; push when full is refused; push and pop in the same cycle are both honoured.
REQ-029 SHALL, without UART_TX_FIFO_EN, instantiate no FIFO and follow REQ-019.

Structure
REQ-030 SHALL put the FSM state encoding, the parity-mode constants (PAR_NONE/PAR_EVEN/PAR_ODD) and a baud-divisor function in shared package uart_pkg.
REQ-031 SHALL implement the FIFO as sub-module uart_tx_fifo (parameters WIDTH, DEPTH), instantiated only under UART_TX_FIFO_EN.

Verification (CLK_FREQ=50_000_000, UART_BPS=5_000_000 -> BAUD_DIV=10)
REQ-032 SHALL cover 8N1 with 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each 10 cycles; tx_done at cycle 100 after start; tx_busy high for 100 cycles.
REQ-033 SHALL cover 8E1 and 8O1 with 0xA5 -> parity bit 0 (even), 1 (odd); frame 110 cycles.
REQ-034 SHALL cover 5N2 with 0x1F -> 0,1,1,1,1,1,1,1; frame 80 cycles; bits 5..7 of tx_data ignored.
REQ-035 SHALL cover rst asserted at cycle 35 of a frame -> rs232_tx=1 next cycle, tx_busy=0, no tx_done.
REQ-036 SHALL cover, with UART_TX_FIFO_EN and FIFO_DEPTH=4, 6 back-to-back valids -> tx_ready drops after the 5th accept (1 in FSM + 4 stored) and 5 frames are transmitted contiguously.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter.
//   tx_state_t   FSM state encoding (IDLE, START, DATA, PAR, STOP)
//   PAR_*        parity-mode constants for the PARITY parameter
//   baud_div()   clocks per line bit, integer division
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } tx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   function automatic int baud_div(input int clk_freq, input int bps);
      return clk_freq / bps;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO buffering bytes ahead of the UART FSM.
// A push into a full FIFO is refused; a pop from an empty FIFO is ignored;
// push and pop in the same cycle are both honoured.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears pointers)
//   push, wdata   write request and data
//   pop           read request; rdata shows the head entry combinationally
//   full, empty   occupancy flags
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit tells full from empty when the indices match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parameterised UART transmitter (DATA_BITS 5..8, none/even/odd
// parity, 1 or 2 stop bits), one line bit every CLK_FREQ/UART_BPS clocks.
// Build option: define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO
// between the tx_valid/tx_ready handshake and the FSM.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   tx_data    payload, bits [DATA_BITS-1:0] used
//   tx_valid   tx_data valid this cycle
//   tx_ready   block accepts tx_data this cycle
//   tx_busy    frame in progress
//   tx_done    one-cycle pulse on the last cycle of the final stop bit
//   rs232_tx   registered serial line, idle high
//
// state | meaning
// IDLE  | line high, waiting for a byte
// START | start bit (low)
// DATA  | payload bits, LSB first
// PAR   | parity bit (skipped when PARITY == PAR_NONE)
// STOP  | STOP_BITS high bit periods, then back to IDLE
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int UART_BPS   = 9600,
   parameter int CLK_FREQ   = 50_000_000,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       rs232_tx
);

   localparam int BAUD_DIV = baud_div(CLK_FREQ, UART_BPS);
   localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(BAUD_DIV - 2);
   localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic [7:0]       DATA_MASK = 8'((1 << DATA_BITS) - 1);

   if (BAUD_DIV < 2) begin : g_bad_baud
      $error("uart_tx_cfg: CLK_FREQ/UART_BPS must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
      $error("uart_tx_cfg: DATA_BITS must be 5..8");
   end
   if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_par
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_cfg: FIFO_DEPTH must be a power of two, at least 2");
   end

   tx_state_t        state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_cnt;
   logic             stop_cnt;
   logic [7:0]       shift_q;
   logic             par_q;
   logic             line_q;
   logic             done_q;
   logic             baud_wrap;

   logic             start_req;
   logic [7:0]       start_data;

`ifdef UART_TX_FIFO_EN
   logic       fifo_full;
   logic       fifo_empty;
   logic [7:0] fifo_rdata;
   logic       fifo_push;
   logic       fifo_pop;

   assign tx_ready   = !fifo_full && !rst;
   assign fifo_push  = tx_valid && tx_ready;
   assign fifo_pop   = (state == IDLE) && !fifo_empty;
   assign start_req  = fifo_pop;
   assign start_data = fifo_rdata;

   uart_tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (tx_data),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
`else
   assign tx_ready   = (state == IDLE) && !rst;
   assign start_req  = tx_valid && tx_ready;
   assign start_data = tx_data;
`endif

   assign baud_wrap = (baud_cnt == BAUD_LAST);
   assign tx_busy   = (state != IDLE);
   assign tx_done   = done_q;
   assign rs232_tx  = line_q;

   // line_q is loaded with the value of the next bit on the edge that
   // enters it, so the registered line lines up with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         line_q   <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state != IDLE) begin
            baud_cnt <= baud_wrap ? '0 : baud_cnt + CNT_W'(1);
         end
         case (state)
            IDLE: begin
               line_q <= 1'b1;
               if (start_req) begin
                  state    <= START;
                  shift_q  <= start_data;
                  // Parity is fixed at capture; bits above DATA_BITS are masked.
                  par_q    <= (^(start_data & DATA_MASK)) ^ (PARITY == PAR_ODD);
                  bit_cnt  <= '0;
                  stop_cnt <= 1'b0;
                  line_q   <= 1'b0;
               end
            end
            START: begin
               if (baud_wrap) begin
                  state  <= DATA;
                  line_q <= shift_q[0];
               end
            end
            DATA: begin
               if (baud_wrap) begin
                  if (bit_cnt == DATA_LAST) begin
                     if (PARITY != PAR_NONE) begin
                        state  <= PAR;
                        line_q <= par_q;
                     end else begin
                        state  <= STOP;
                        line_q <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     shift_q <= shift_q >> 1;
                     line_q  <= shift_q[1];
                  end
               end
            end
            PAR: begin
               if (baud_wrap) begin
                  state  <= STOP;
                  line_q <= 1'b1;
               end
            end
            STOP: begin
               line_q <= 1'b1;
               if (stop_cnt == STOP_LAST && baud_cnt == BAUD_PRE) done_q <= 1'b1;
               if (baud_wrap) begin
                  if (stop_cnt == STOP_LAST) state <= IDLE;
                  else stop_cnt <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               line_q <= 1'b1;
            end
         endcase
      end
   end

endmodule
